// File: rtl/core_mem_arbiter_pkg.sv
// Shared bus typedefs for the core's ibus/dbus ports and the memory arbiter's state/owner enums.
// Latency: n/a (types only).
// Backpressure: n/a.
package core_mem_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;

    // Instruction fetches are always 32-bit words.
    localparam logic [2:0] MSIZE_WORD = 3'b010;

endpackage

// File: rtl/core_mem_arbiter_arb_priority.sv
// Grant select between ibus and dbus with fixed dbus priority and an ibus starvation cap.
// Latency: grant is combinational; streak counter updates on the granting edge.
// Backpressure: grants only when grant_en (arbiter idle); a losing requester simply stays pending.
module arb_priority #(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
    input  logic ivalid,
    input  logic dvalid,
    output logic gnt_i,
    output logic gnt_d
);

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

    logic [CNT_W-1:0] streak;
    logic             force_i;

    // dbus wins unless ibus has waited through MAX_D_STREAK consecutive dbus grants.
    always_comb begin
        force_i = ivalid && (streak == STREAK_MAX);
        gnt_d   = grant_en && dvalid && !force_i;
        gnt_i   = grant_en && ivalid && !gnt_d;
    end

    // Count dbus grants made while ibus was waiting; any other grant restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (gnt_d) begin
            if (!ivalid)
                streak <= '0;
            else if (streak != STREAK_MAX)
                streak <= streak + 1'b1;
        end else if (gnt_i) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Serialises the core's ibus and dbus onto one single-port memory, one transaction in flight.
// Latency: 4 cycles minimum (grant, request accepted, response, one-cycle RESP to core).
// Backpressure: holds mreq_* stable until mreq_ready; requesters wait in IDLE until granted.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 3   // must satisfy MAX_D_STREAK < 2**CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  ibus_req_t   ireq,
    output ibus_resp_t  iresp,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic        mreq_valid,
    output logic        mreq_is_write,
    output logic [63:0] mreq_addr,
    output logic [2:0]  mreq_size,
    output logic [7:0]  mreq_strobe,
    output logic [63:0] mreq_data,
    input  logic        mreq_ready,
    input  logic        mresp_valid,
    input  logic [63:0] mresp_data
);

    arb_state_t  state, state_nxt;
    arb_owner_t  owner;
    logic        abort;
    logic [63:0] lat_addr, lat_data, lat_rdata;
    logic [2:0]  lat_size;
    logic [7:0]  lat_strobe;
    logic        gnt_i, gnt_d;
    logic        owner_valid, resp_ok;

    assign owner_valid = (owner == OWN_I) ? ireq.valid : dreq.valid;

    arb_priority #(
        .MAX_D_STREAK(MAX_D_STREAK),
        .CNT_W       (CNT_W)
    ) u_prio (
        .clk     (clk),
        .reset   (reset),
        .grant_en(state == IDLE),
        .ivalid  (ireq.valid),
        .dvalid  (dreq.valid),
        .gnt_i   (gnt_i),
        .gnt_d   (gnt_d)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus all core/memory facing outputs.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_i || gnt_d) state_nxt = REQ;
            REQ:     if (mreq_ready)     state_nxt = WAIT;
            WAIT:    if (mresp_valid)    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A requester that dropped valid mid-transaction gets no handshake back.
        resp_ok       = (state == RESP) && !abort && owner_valid;
        mreq_valid    = (state == REQ);
        mreq_is_write = |lat_strobe;
        mreq_addr     = lat_addr;
        mreq_size     = lat_size;
        mreq_strobe   = lat_strobe;
        mreq_data     = lat_data;

        iresp = '0;
        dresp = '0;
        if (resp_ok && owner == OWN_I) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = lat_addr[2] ? lat_rdata[63:32] : lat_rdata[31:0];
        end
        if (resp_ok && owner == OWN_D) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = lat_rdata;
        end
    end

    // Capture the winning request on grant and the memory read data on response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_I;
            lat_addr   <= '0;
            lat_size   <= '0;
            lat_strobe <= '0;
            lat_data   <= '0;
            lat_rdata  <= '0;
        end else if (gnt_d) begin
            owner      <= OWN_D;
            lat_addr   <= dreq.addr;
            lat_size   <= dreq.size;
            lat_strobe <= dreq.strobe;
            lat_data   <= dreq.data;
        end else if (gnt_i) begin
            owner      <= OWN_I;
            lat_addr   <= ireq.addr;
            lat_size   <= MSIZE_WORD;
            lat_strobe <= '0;
            lat_data   <= '0;
        end else if (state == WAIT && mresp_valid) begin
            lat_rdata  <= mresp_data;
        end
    end

    // Remember an owner valid drop anywhere in REQ..RESP; forget it on return to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            abort <= 1'b0;
        else if (state_nxt == IDLE)
            abort <= 1'b0;
        else if (state != IDLE && !owner_valid)
            abort <= 1'b1;
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: fetch, write, priority cap, stalls, abort, async reset.
// Latency: inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpressure: memory ready/response driven by hand per step.
module tb_core_mem_arbiter;
    import core_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        mreq_valid, mreq_is_write;
    logic [63:0] mreq_addr, mreq_data;
    logic [2:0]  mreq_size;
    logic [7:0]  mreq_strobe;
    logic        mreq_ready, mresp_valid;
    logic [63:0] mresp_data;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    core_mem_arbiter #(.MAX_D_STREAK(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .ireq         (ireq),
        .iresp        (iresp),
        .dreq         (dreq),
        .dresp        (dresp),
        .mreq_valid   (mreq_valid),
        .mreq_is_write(mreq_is_write),
        .mreq_addr    (mreq_addr),
        .mreq_size    (mreq_size),
        .mreq_strobe  (mreq_strobe),
        .mreq_data    (mreq_data),
        .mreq_ready   (mreq_ready),
        .mresp_valid  (mresp_valid),
        .mresp_data   (mresp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        ireq        = '0;
        dreq        = '0;
        mreq_ready  = 1'b0;
        mresp_valid = 1'b0;
        mresp_data  = '0;
        tick();
        tick();
        check("rst_mreq_valid", 64'(mreq_valid), 64'd0);
        check("rst_mreq_addr", mreq_addr, 64'd0);
        check("rst_iresp", 64'(iresp), 64'd0);
        check("rst_dresp", 64'(dresp), 64'd0);
        reset = 1'b0;

        // ---- ibus fetch, upper word selected by addr[2]
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0004;
        mreq_ready = 1'b1;
        tick();                                            // c1 REQ
        check("t1_mreq_valid", 64'(mreq_valid), 64'd1);
        check("t1_is_write", 64'(mreq_is_write), 64'd0);
        check("t1_size", 64'(mreq_size), 64'd2);
        check("t1_addr", mreq_addr, 64'h8000_0004);
        tick();                                            // c2 WAIT
        mreq_ready  = 1'b0;
        mresp_valid = 1'b1;
        mresp_data  = 64'hAAAA_BBBB_CCCC_DDDD;
        check("t1_wait_no_ok", 64'(iresp.data_ok), 64'd0);
        tick();                                            // c3 RESP
        mresp_valid = 1'b0;
        check("t1_data_ok", 64'(iresp.data_ok), 64'd1);
        check("t1_addr_ok", 64'(iresp.addr_ok), 64'd1);
        check("t1_data", 64'(iresp.data), 64'hAAAA_BBBB);
        tick();                                            // c4 IDLE
        ireq.valid = 1'b0;
        check("t1_idle_ok", 64'(iresp.data_ok), 64'd0);

        // ---- both valid: dbus write wins, ibus served afterwards
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h200;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h100;
        dreq.size   = 3'b011;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'h1234;
        mreq_ready  = 1'b1;
        tick();                                            // c1
        check("t2_is_write", 64'(mreq_is_write), 64'd1);
        check("t2_strobe", 64'(mreq_strobe), 64'h0F);
        check("t2_addr", mreq_addr, 64'h100);
        check("t2_data", mreq_data, 64'h1234);
        tick();                                            // c2
        mreq_ready  = 1'b0;
        mresp_valid = 1'b1;
        mresp_data  = 64'h0;
        tick();                                            // c3
        mresp_valid = 1'b0;
        check("t2_dresp_ok", 64'(dresp.data_ok), 64'd1);
        check("t2_iresp_quiet", 64'(iresp.data_ok), 64'd0);
        tick();                                            // c4 IDLE
        dreq.valid = 1'b0;
        mreq_ready = 1'b1;
        tick();                                            // ibus REQ
        check("t2_i_is_write", 64'(mreq_is_write), 64'd0);
        check("t2_i_addr", mreq_addr, 64'h200);
        check("t2_i_strobe", 64'(mreq_strobe), 64'd0);
        tick();
        mreq_ready  = 1'b0;
        mresp_valid = 1'b1;
        mresp_data  = 64'h5555_6666_7777_8888;
        tick();
        mresp_valid = 1'b0;
        check("t2_i_data_ok", 64'(iresp.data_ok), 64'd1);
        check("t2_i_data", 64'(iresp.data), 64'h7777_8888);
        check("t2_dresp_quiet", 64'(dresp.data_ok), 64'd0);
        tick();                                            // IDLE
        ireq.valid = 1'b0;

        // ---- starvation cap: four dbus grants then ibus
        ireq.valid = 1'b1;
        dreq.valid = 1'b1;
        mreq_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();                                        // REQ
            check("t3_is_write", 64'(mreq_is_write), (k < 4) ? 64'd1 : 64'd0);
            check("t3_streak", 64'(dut.u_prio.streak), (k < 4) ? 64'(k + 1) : 64'd0);
            tick();                                        // WAIT
            mreq_ready  = 1'b0;
            mresp_valid = 1'b1;
            tick();                                        // RESP
            mresp_valid = 1'b0;
            mreq_ready  = 1'b1;
            check("t3_dresp_ok", 64'(dresp.data_ok), (k < 4) ? 64'd1 : 64'd0);
            check("t3_iresp_ok", 64'(iresp.data_ok), (k < 4) ? 64'd0 : 64'd1);
            tick();                                        // IDLE
        end
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        mreq_ready = 1'b0;

        // ---- memory stalls the request for 5 cycles; later field changes ignored
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h2008;
        dreq.size   = 3'b011;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_hold_valid", 64'(mreq_valid), 64'd1);
            check("t4_hold_addr", mreq_addr, 64'h2008);
            dreq.addr = 64'hFFFF_0000;
        end
        mreq_ready = 1'b1;
        tick();                                            // WAIT
        mreq_ready = 1'b0;
        check("t4_wait_valid", 64'(mreq_valid), 64'd0);
        tick();
        check("t4_wait_no_ok", 64'(dresp.data_ok), 64'd0);
        mresp_valid = 1'b1;
        mresp_data  = 64'hDEAD_BEEF_0123_4567;
        tick();                                            // RESP
        mresp_valid = 1'b0;
        check("t4_data_ok", 64'(dresp.data_ok), 64'd1);
        check("t4_data", dresp.data, 64'hDEAD_BEEF_0123_4567);
        tick();                                            // IDLE
        dreq.valid = 1'b0;
        check("t4_ok_once", 64'(dresp.data_ok), 64'd0);

        // ---- ibus abort in WAIT
        ireq.valid = 1'b1;
        ireq.addr  = 64'h10;
        mreq_ready = 1'b1;
        tick();                                            // REQ
        tick();                                            // WAIT
        mreq_ready = 1'b0;
        ireq.valid = 1'b0;
        tick();                                            // still WAIT
        check("t5_abort_set", 64'(dut.abort), 64'd1);
        mresp_valid = 1'b1;
        mresp_data  = 64'h1111_2222_3333_4444;
        tick();                                            // RESP
        mresp_valid = 1'b0;
        check("t5_state_resp", 64'(dut.state), 64'(RESP));
        check("t5_data_ok", 64'(iresp.data_ok), 64'd0);
        check("t5_addr_ok", 64'(iresp.addr_ok), 64'd0);
        tick();
        check("t5_state_idle", 64'(dut.state), 64'(IDLE));
        check("t5_abort_clr", 64'(dut.abort), 64'd0);

        // ---- asynchronous reset mid-WAIT, then a fresh dbus read
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h40;
        dreq.strobe = 8'h00;
        mreq_ready  = 1'b1;
        tick();                                            // REQ
        tick();                                            // WAIT
        mreq_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t6_state", 64'(dut.state), 64'(IDLE));
        check("t6_mreq_addr", mreq_addr, 64'd0);
        check("t6_mreq_valid", 64'(mreq_valid), 64'd0);
        check("t6_dresp", 64'(dresp), 64'd0);
        #1 reset = 1'b0;
        dreq.addr  = 64'h48;
        mreq_ready = 1'b1;
        tick();                                            // c1
        check("t6_req_addr", mreq_addr, 64'h48);
        check("t6_req_valid", 64'(mreq_valid), 64'd1);
        tick();                                            // c2
        mreq_ready  = 1'b0;
        mresp_valid = 1'b1;
        mresp_data  = 64'h0BAD_F00D_CAFE_0001;
        tick();                                            // c3
        mresp_valid = 1'b0;
        check("t6_data_ok", 64'(dresp.data_ok), 64'd1);
        check("t6_data", dresp.data, 64'h0BAD_F00D_CAFE_0001);
        dreq.valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
